change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Hopper-side end of the change path. Takes a change amount in cents from the
//  balance/payment logic and physically pays it out, one coin at a time, from
//  quarter, dime and nickel hoppers. Each coin uses a pulse/ack handshake with
//  the hopper coin sensor. Reports the coins actually paid, any unpaid remainder,
//  and hopper faults. Sits between the balance logic and the coin-mech drivers.
// PARAMETERS
//  PULSE_CYCLES  4     eject pulse width in clk cycles (>=1)
//  ACK_TIMEOUT   1000  cycles from pulse start to hopper_ack before a fault (>=PULSE_CYCLES+1)
//  STOCK_W       8     width of each hopper stock counter
// PORTS
//  clk           in   1        1 MHz system clock; all logic on posedge
//  rst           in   1        synchronous reset, active-low
//  req           in   1        start payout; sampled only in IDLE
//  change_cents  in   9        amount to pay; sampled with req; must be a multiple of 5
//  load_stock    in   1        in IDLE, load the stock_*_in values into the stock counters
//  stock_q_in    in   STOCK_W  quarter stock load value
//  stock_d_in    in   STOCK_W  dime stock load value
//  stock_n_in    in   STOCK_W  nickel stock load value
//  hopper_ack    in   1        coin-sensor pulse; the ejected coin has left the machine
//  eject_q       out  1        quarter eject pulse
//  eject_d       out  1        dime eject pulse
//  eject_n       out  1        nickel eject pulse
//  busy          out  1        high from the cycle after req is accepted until DONE/FAULT
//  done          out  1        one-cycle pulse when the payout ends (full or short)
//  short_pay     out  1        held: last payout left an unpaid remainder
//  fault         out  1        held: hopper ack timeout
//  remaining     out  9        cents still owed
//  quarter_o     out  5        quarters paid in the current/last payout
//  dime_o        out  5        dimes paid in the current/last payout
//  nickel_o      out  5        nickels paid in the current/last payout
//  stock_q/d/n   out  STOCK_W  current hopper stock counts
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//  - state IDLE; all outputs 0, including stock counters.
//  - Reset mid-payout aborts immediately; pulses drop on the next edge.
//  FSM: IDLE -> SELECT -> EJECT -> WAIT_ACK -> SELECT ... -> DONE -> IDLE; WAIT_ACK -> FAULT.
//  IDLE:
//  - req=1: latch change_cents into remaining.
//  - Clear quarter_o/dime_o/nickel_o, short_pay and fault; go to SELECT.
//  - change_cents[0] or a non-multiple of 5: round down to a multiple of 5 (remaining = cents - cents%5).
//  - load_stock in the same cycle as req: the load applies first, then req is accepted.
//  - load_stock is ignored outside IDLE.
//  SELECT (1 cycle), greedy coin choice:
//  - Quarter if remaining>=25 and stock_q>0; else dime if remaining>=10 and stock_d>0;
//    else nickel if remaining>=5 and stock_n>0.
//  - Coin chosen -> EJECT.
//  - No coin possible -> DONE; short_pay = (remaining!=0).
//  EJECT:
//  - Assert the chosen eject_* for exactly PULSE_CYCLES cycles.
//  - At most one eject_* is high in any cycle.
//  - The ack timer starts on the first pulse cycle.
//  WAIT_ACK:
//  - hopper_ack is accepted during the pulse or after it.
//  - On ack: remaining -= coin value; stock_x decrements; x_o increments (saturates at 31);
//    go to SELECT.
//  - An ack arriving while in IDLE/SELECT/DONE is ignored.
//  - No ack within ACK_TIMEOUT cycles of pulse start -> FAULT (if ACK_TIMEOUT_EN).
//  DONE: done=1 for one cycle; busy drops; go to IDLE.
//  FAULT:
//  - fault=1, done=1 for one cycle, then IDLE.
//  - remaining and counts keep the values reached at the fault.
//  - The faulted coin is not counted and stock is not decremented.
//  change_cents==0 with req: SELECT -> DONE in 2 cycles, no ejects, short_pay=0.
//  A req asserted while busy is ignored (no queueing).
//  Arithmetic: remaining never underflows; the coin is chosen only if remaining >= its value.
// CONFIGURATION
//  ACK_TIMEOUT_EN:
//  - Defined: the WAIT_ACK timeout counter and the FAULT path are built.
//  - Undefined: no timeout counter; WAIT_ACK waits indefinitely for hopper_ack; fault is tied to 0.
// TESTING
//  1 stock q/d/n=10/10/10; req, change=65 -> ejects Q,Q,D,N in order; counts 2/1/1;
//    remaining 0; done; short_pay=0; stock 8/9/9.
//  2 stock q=0,d=1,n=1; change=40 -> D,N paid; remaining=25; short_pay=1; done after the 2nd ack.
//  3 change=0 -> done 2 cycles after req; no eject pulse; busy high for exactly 1 cycle.
//  4 ACK_TIMEOUT_EN, ACK_TIMEOUT=20; withhold hopper_ack on the first quarter ->
//    fault=1 at cycle 20 after the pulse start; quarter_o=0; stock_q unchanged.
//  5 rst low during the 2nd eject of a 50-cent payout -> next cycle: all outputs 0, IDLE;
//    a new req is then accepted normally.
//  6 req pulsed again while busy and a stray hopper_ack sent in IDLE ->
//    both ignored; counts and stock unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy quarter/dime/nickel payout with pulse/ack hopper handshake
// Optional feature macro: ACK_TIMEOUT_EN builds the hopper ack timeout counter and FAULT path.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000,
  parameter int STOCK_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [8:0]         change_cents,
  input  logic               load_stock,
  input  logic [STOCK_W-1:0] stock_q_in,
  input  logic [STOCK_W-1:0] stock_d_in,
  input  logic [STOCK_W-1:0] stock_n_in,
  input  logic               hopper_ack,
  output logic               eject_q,
  output logic               eject_d,
  output logic               eject_n,
  output logic               busy,
  output logic               done,
  output logic               short_pay,
  output logic               fault,
  output logic [8:0]         remaining,
  output logic [4:0]         quarter_o,
  output logic [4:0]         dime_o,
  output logic [4:0]         nickel_o,
  output logic [STOCK_W-1:0] stock_q,
  output logic [STOCK_W-1:0] stock_d,
  output logic [STOCK_W-1:0] stock_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_EJECT    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [1:0] C_Q = 2'd0;
  localparam logic [1:0] C_D = 2'd1;
  localparam logic [1:0] C_N = 2'd2;

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [2:0]    state;
  logic [1:0]    coin;
  logic [PW-1:0] pulse_cnt;
  logic          ack_pend;

  logic [8:0] rounded;
  logic [8:0] coin_val;
  logic       pick_q;
  logic       pick_d;
  logic       pick_n;
  logic       pulse_last;
  logic       pay;
  logic       timeout;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_comb begin
    rounded = change_cents - (change_cents % 9'd5);
    case (coin)
      C_Q:     coin_val = 9'd25;
      C_D:     coin_val = 9'd10;
      C_N:     coin_val = 9'd5;
      default: coin_val = 9'd0;
    endcase
  end

  // Greedy: largest coin that fits the remainder and is still in stock.
  assign pick_q = (remaining >= 9'd25) && (stock_q != '0);
  assign pick_d = (remaining >= 9'd10) && (stock_d != '0);
  assign pick_n = (remaining >= 9'd5)  && (stock_n != '0);

  assign pulse_last = (pulse_cnt == PW'(PULSE_CYCLES - 1));

  // An ack seen during the pulse is held until the pulse has run its full width.
  assign pay = ((state == S_EJECT) && pulse_last && (ack_pend || hopper_ack)) ||
               ((state == S_WAIT_ACK) && hopper_ack);

`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] ack_timer;
  logic          fault_r;

  assign timeout = (state == S_WAIT_ACK) && !hopper_ack &&
                   (ack_timer == TW'(ACK_TIMEOUT - 1));
  assign fault   = fault_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_timer <= '0;
      fault_r   <= 1'b0;
    end else begin
      if (state == S_SELECT) begin
        ack_timer <= '0;
      end else if ((state == S_EJECT) || (state == S_WAIT_ACK)) begin
        ack_timer <= ack_timer + TW'(1);
      end
      if ((state == S_IDLE) && req) begin
        fault_r <= 1'b0;
      end else if (timeout) begin
        fault_r <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      coin      <= C_Q;
      pulse_cnt <= '0;
      ack_pend  <= 1'b0;
      short_pay <= 1'b0;
      remaining <= '0;
      quarter_o <= '0;
      dime_o    <= '0;
      nickel_o  <= '0;
      stock_q   <= '0;
      stock_d   <= '0;
      stock_n   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_stock) begin
            stock_q <= stock_q_in;
            stock_d <= stock_d_in;
            stock_n <= stock_n_in;
          end
          if (req) begin
            remaining <= rounded;
            quarter_o <= '0;
            dime_o    <= '0;
            nickel_o  <= '0;
            short_pay <= 1'b0;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          pulse_cnt <= '0;
          ack_pend  <= 1'b0;
          if (pick_q) begin
            coin  <= C_Q;
            state <= S_EJECT;
          end else if (pick_d) begin
            coin  <= C_D;
            state <= S_EJECT;
          end else if (pick_n) begin
            coin  <= C_N;
            state <= S_EJECT;
          end else begin
            short_pay <= (remaining != '0);
            state     <= S_DONE;
          end
        end
        S_EJECT: begin
          if (hopper_ack) begin
            ack_pend <= 1'b1;
          end
          if (pulse_last) begin
            state <= pay ? S_SELECT : S_WAIT_ACK;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (pay) begin
            state <= S_SELECT;
          end else if (timeout) begin
            state <= S_FAULT;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (pay) begin
        remaining <= remaining - coin_val;
        case (coin)
          C_Q: begin
            stock_q   <= stock_q - STOCK_W'(1);
            quarter_o <= sat_inc(quarter_o);
          end
          C_D: begin
            stock_d <= stock_d - STOCK_W'(1);
            dime_o  <= sat_inc(dime_o);
          end
          default: begin
            stock_n  <= stock_n - STOCK_W'(1);
            nickel_o <= sat_inc(nickel_o);
          end
        endcase
      end
    end
  end

  assign eject_q = (state == S_EJECT) && (coin == C_Q);
  assign eject_d = (state == S_EJECT) && (coin == C_D);
  assign eject_n = (state == S_EJECT) && (coin == C_N);
  assign busy    = (state == S_SELECT) || (state == S_EJECT) || (state == S_WAIT_ACK);
  assign done    = (state == S_DONE) || (state == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized payouts checked every cycle against a greedy coin model
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int PULSE_CYCLES = 4;
  localparam int ACK_TIMEOUT  = 20;
  localparam int STOCK_W      = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, req, load_stock, hopper_ack;
  logic [8:0]         change_cents;
  logic [STOCK_W-1:0] sq_in, sd_in, sn_in;
  logic               eject_q, eject_d, eject_n, busy, done, short_pay, fault;
  logic [8:0]         remaining;
  logic [4:0]         quarter_o, dime_o, nickel_o;
  logic [STOCK_W-1:0] stock_q, stock_d, stock_n;

  change_dispenser #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .STOCK_W     (STOCK_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .change_cents(change_cents),
    .load_stock(load_stock), .stock_q_in(sq_in), .stock_d_in(sd_in), .stock_n_in(sn_in),
    .hopper_ack(hopper_ack),
    .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
    .busy(busy), .done(done), .short_pay(short_pay), .fault(fault),
    .remaining(remaining), .quarter_o(quarter_o), .dime_o(dime_o), .nickel_o(nickel_o),
    .stock_q(stock_q), .stock_d(stock_d), .stock_n(stock_n)
  );

  // Model: index 0/1/2 = quarter/dime/nickel
  int       e_rem;
  int       e_cnt [3];
  int       e_stk [3];
  bit       e_busy, e_done, e_short, e_fault;
  bit [2:0] e_ej;
  bit       chk_en;

  int    n_chk, n_pass;
  int    lit_seq, lit_seen, lit_sel, lit_exp, lit_act;
  string lit_name;
  logic [54:0] act_v, exp_v;

  function automatic int coin_val(input int c);
    return (c == 0) ? 25 : (c == 1) ? 10 : 5;
  endfunction

  function automatic int pick();
    for (int c = 0; c < 3; c++)
      if (e_rem >= coin_val(c) && e_stk[c] > 0) return c;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      act_v = {eject_q, eject_d, eject_n, busy, done, short_pay, fault, remaining,
               quarter_o, dime_o, nickel_o, stock_q, stock_d, stock_n};
      exp_v = {e_ej, e_busy, e_done, e_short, e_fault, 9'(e_rem),
               5'(e_cnt[0]), 5'(e_cnt[1]), 5'(e_cnt[2]),
               8'(e_stk[0]), 8'(e_stk[1]), 8'(e_stk[2])};
      n_chk++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      case (lit_sel)
        0:       lit_act = int'(remaining);
        1:       lit_act = int'(quarter_o);
        2:       lit_act = int'(dime_o);
        3:       lit_act = int'(nickel_o);
        4:       lit_act = int'(stock_q);
        5:       lit_act = int'(stock_d);
        6:       lit_act = int'(stock_n);
        7:       lit_act = int'(short_pay);
        default: lit_act = int'(fault);
      endcase
      n_chk++;
      if (lit_act == lit_exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", lit_name, lit_act, lit_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int sel, input int expv);
    lit_name = name;
    lit_sel  = sel;
    lit_exp  = expv;
    lit_seq++;
    tick();
  endtask

  task automatic model_clear_all();
    e_rem = 0; e_busy = 0; e_done = 0; e_short = 0; e_fault = 0; e_ej = '0;
    for (int i = 0; i < 3; i++) begin e_cnt[i] = 0; e_stk[i] = 0; end
  endtask

  task automatic noise_in(input bit en);
    if (en) begin
      req          = 1'($urandom_range(0, 1));
      change_cents = 9'($urandom_range(0, 511));
      load_stock   = 1'($urandom_range(0, 1));
      sq_in = 8'($urandom); sd_in = 8'($urandom); sn_in = 8'($urandom);
    end
  endtask

  task automatic quiet();
    req = 1'b0;
    load_stock = 1'b0;
  endtask

  task automatic load(input int q, input int d, input int n);
    load_stock = 1'b1; sq_in = 8'(q); sd_in = 8'(d); sn_in = 8'(n);
    tick();
    load_stock = 1'b0;
    e_stk[0] = q; e_stk[1] = d; e_stk[2] = n;
  endtask

  task automatic idle(input int cycles, input bit stray);
    for (int i = 0; i < cycles; i++) begin
      hopper_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    hopper_ack = 1'b0;
  endtask

  // withhold: coin index whose ack is held back; rst_coin: coin index whose pulse is cut by reset
  task automatic payout(input int cents, input bit ld, input int lq, input int ldd, input int ln,
                        input int withhold, input int rst_coin, input bit noise);
    int c, idx, n;
    req = 1'b1; change_cents = 9'(cents); load_stock = ld;
    if (ld) begin sq_in = 8'(lq); sd_in = 8'(ldd); sn_in = 8'(ln); end
    tick();
    quiet();
    if (ld) begin e_stk[0] = lq; e_stk[1] = ldd; e_stk[2] = ln; end
    e_rem = cents - cents % 5;
    for (int i = 0; i < 3; i++) e_cnt[i] = 0;
    e_short = 0; e_fault = 0; e_busy = 1; e_done = 0; e_ej = '0;
    idx = 0;
    forever begin
      c = pick();
      hopper_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c < 0) begin
        tick();
        e_busy = 0; e_done = 1; e_short = (e_rem != 0);
        tick();
        hopper_ack = 1'b0;
        e_done = 0;
        return;
      end
      tick();
      hopper_ack = 1'b0;
      e_ej = 3'(3'b100 >> c);
      if (idx == rst_coin) begin
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_clear_all();
        return;
      end
`ifdef ACK_TIMEOUT_EN
      if (idx == withhold) begin
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
          noise_in(noise);
          tick();
          if (i >= PULSE_CYCLES) e_ej = '0;
        end
        quiet();
        tick();
        e_ej = '0; e_busy = 0; e_done = 1; e_fault = 1;
        tick();
        e_done = 0;
        return;
      end
      n = PULSE_CYCLES - 1 + $urandom_range(0, 3);
`else
      n = PULSE_CYCLES - 1 + ((idx == withhold) ? 30 : $urandom_range(0, 3));
`endif
      for (int i = 1; i <= n; i++) begin
        noise_in(noise);
        tick();
        if (i >= PULSE_CYCLES) e_ej = '0;
      end
      quiet();
      hopper_ack = 1'b1;
      tick();
      hopper_ack = 1'b0;
      e_ej = '0;
      e_rem -= coin_val(c);
      e_stk[c] -= 1;
      if (e_cnt[c] < 31) e_cnt[c] += 1;
      idx++;
    end
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; load_stock = 1'b0; hopper_ack = 1'b0; change_cents = '0;
    sq_in = '0; sd_in = '0; sn_in = '0;
    n_chk = 0; n_pass = 0; lit_seq = 0; lit_seen = 0; chk_en = 0;
    model_clear_all();
    tick();
    chk_en = 1;
    tick();
    tick();
    rst = 1'b1;
    tick();

    load(10, 10, 10);
    payout(65, 0, 0, 0, 0, -1, -1, 0);
    lit("t1_quarters", 1, 2);
    lit("t1_dimes", 2, 1);
    lit("t1_nickels", 3, 1);
    lit("t1_remaining", 0, 0);
    lit("t1_short", 7, 0);
    lit("t1_stock_q", 4, 8);
    lit("t1_stock_d", 5, 9);
    lit("t1_stock_n", 6, 9);

    load(0, 1, 1);
    payout(40, 0, 0, 0, 0, -1, -1, 0);
    lit("t2_remaining", 0, 25);
    lit("t2_short", 7, 1);
    lit("t2_dimes", 2, 1);
    lit("t2_nickels", 3, 1);

    payout(0, 0, 0, 0, 0, -1, -1, 0);
    lit("t3_short", 7, 0);

    load(5, 5, 5);
    payout(25, 0, 0, 0, 0, 0, -1, 0);
`ifdef ACK_TIMEOUT_EN
    lit("t4_fault", 8, 1);
    lit("t4_quarters", 1, 0);
    lit("t4_stock_q", 4, 5);
`else
    lit("t4_fault", 8, 0);
    lit("t4_quarters", 1, 1);
    lit("t4_stock_q", 4, 4);
`endif

    load(10, 10, 10);
    payout(50, 0, 0, 0, 0, -1, 1, 0);
    lit("t5_stock_q_after_reset", 4, 0);
    load(3, 3, 3);
    payout(35, 0, 0, 0, 0, -1, -1, 0);
    lit("t5_quarters", 1, 1);
    lit("t5_dimes", 2, 1);

    load(4, 4, 4);
    payout(30, 0, 0, 0, 0, -1, -1, 1);
    idle(12, 1);
    lit("t6_stock_q", 4, 3);
    lit("t6_stock_n", 6, 3);
    lit("t6_nickels", 3, 1);

    payout(15, 1, 0, 1, 5, -1, -1, 0);
    lit("load_with_req_stock_d", 5, 0);
    load(0, 0, 40);
    payout(200, 0, 0, 0, 0, -1, -1, 0);
    lit("sat_nickels", 3, 31);
    lit("sat_remaining", 0, 0);
    load(10, 10, 10);
    payout(37, 0, 0, 0, 0, -1, -1, 0);
    lit("round_dimes", 2, 1);

    for (int k = 0; k < 25; k++) begin
      payout($urandom_range(0, 511), 1'($urandom_range(0, 1)),
             $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 12),
             -1, -1, 1);
      idle($urandom_range(1, 4), 1);
      if (e_stk[0] + e_stk[1] + e_stk[2] < 6)
        load($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
    end

    tick();
    chk_en = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
